// File: rtl/wb_regfile.sv
// wb_regfile: architectural GPR file at the write-back end of the pipeline.
// One write-back port (commit on clk), NUM_RD combinational read ports for
// decode, plus a registered retire trace and commit counter for debug.
// Register 0 is hardwired to zero; writes to it are dropped and never count.
// Optional build macro: REGFILE_WB_BYPASS_EN enables same-cycle write-to-read
// forwarding on every read port (default: no forwarding).

// Single read port: priority reset > enable > r0 > bypass > storage.
module wb_regfile_rport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic                          rst,
    input  logic                          ren,
    input  logic [ADDR_W-1:0]             raddr,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [NREGS-1:0][DATA_W-1:0]  regs,
    output logic [DATA_W-1:0]             rdata
);

`ifdef REGFILE_WB_BYPASS_EN
    logic byp_hit;
    assign byp_hit = we && (waddr != '0) && (raddr == waddr);
`else
    logic unused_wb;
    assign unused_wb = &{1'b0, we, waddr, wdata};
`endif

    // Read mux in priority order; r0 reads zero regardless of storage.
    always_comb begin
        rdata = '0;
        if (rst || !ren || raddr == '0) begin
            rdata = '0;
        end
`ifdef REGFILE_WB_BYPASS_EN
        else if (byp_hit) begin
            rdata = wdata;
        end
`endif
        else begin
            rdata = regs[raddr];
        end
    end

endmodule

module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_waddr,
    output logic [DATA_W-1:0] trace_wdata,
    output logic [CNT_W-1:0]  commit_cnt
);

    localparam int NREGS  = 2**ADDR_W;
    localparam int NUM_RD = 2;
    localparam int STAGES = 1;

    logic [NREGS-1:0][DATA_W-1:0]  regs;
    logic [NUM_RD-1:0]             ren_v;
    logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
    logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;
    logic [STAGES:0]               vld_pipe;

    // A commit is a write-back to any register other than r0.
    assign vld_pipe[0] = we && (waddr != '0);

    // Storage: entry 0 is never written, so it stays at its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (vld_pipe[0]) begin
            regs[waddr] <= wdata;
        end
    end

    // Retire trace: valid pulses for one cycle, address/data hold last commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            trace_waddr        <= '0;
            trace_wdata        <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0]) begin
                trace_waddr <= waddr;
                trace_wdata <= wdata;
            end
        end
    end

    // Commit counter, wraps modulo 2**CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_cnt <= '0;
        end else if (vld_pipe[0]) begin
            commit_cnt <= commit_cnt + CNT_W'(1);
        end
    end

    assign trace_valid = vld_pipe[STAGES];

    assign ren_v   = {re2, re1};
    assign raddr_v = {raddr2, raddr1};

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_rport
            wb_regfile_rport #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NREGS  (NREGS)
            ) u_rport (
                .rst   (rst),
                .ren   (ren_v[p]),
                .raddr (raddr_v[p]),
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
                .regs  (regs),
                .rdata (rdata_v[p])
            );
        end
    endgenerate

    assign rdata1 = rdata_v[0];
    assign rdata2 = rdata_v[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. Counter is built 4 bits wide so wrap is cheap.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1, re2;
    logic [ADDR_W-1:0] raddr1, raddr2;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              trace_valid;
    logic [ADDR_W-1:0] trace_waddr;
    logic [DATA_W-1:0] trace_wdata;
    logic [CNT_W-1:0]  commit_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re1         (re1),
        .raddr1      (raddr1),
        .rdata1      (rdata1),
        .re2         (re2),
        .raddr2      (raddr2),
        .rdata2      (rdata2),
        .trace_valid (trace_valid),
        .trace_waddr (trace_waddr),
        .trace_wdata (trace_wdata),
        .commit_cnt  (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        step();
        chk("rst_trace_valid", trace_valid, 0);
        chk("rst_trace_waddr", trace_waddr, 0);
        chk("rst_trace_wdata", trace_wdata, 0);
        chk("rst_commit_cnt", commit_cnt, 0);
        re1 = 1'b1; raddr1 = 5;
        #1 chk("rst_rdata1", rdata1, 0);
        rst = 1'b0;

        // Write r5, then async reset mid-cycle wipes everything at once.
        we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
        step();
        we = 1'b0;
        #1 chk("pre_rst_rdata1", rdata1, 32'hDEADBEEF);
        chk("pre_rst_cnt", commit_cnt, 1);
        rst = 1'b1;
        #1 chk("async_rst_rdata1", rdata1, 0);
        chk("async_rst_trace_valid", trace_valid, 0);
        chk("async_rst_trace_wdata", trace_wdata, 0);
        chk("async_rst_cnt", commit_cnt, 0);
        // A write presented while in reset is lost.
        we = 1'b1; waddr = 4; wdata = 32'h44;
        step();
        we = 1'b0; rst = 1'b0;
        step();
        #1 chk("post_rst_r5", rdata1, 0);
        raddr1 = 4;
        #1 chk("rst_write_lost_r4", rdata1, 0);
        chk("post_rst_cnt", commit_cnt, 0);

        // Basic write/read and trace pulse.
        we = 1'b1; waddr = 3; wdata = 32'h12345678; raddr1 = 3;
        step();
        we = 1'b0;
        #1 chk("basic_rdata1", rdata1, 32'h12345678);
        chk("basic_trace_valid", trace_valid, 1);
        chk("basic_trace_waddr", trace_waddr, 3);
        chk("basic_trace_wdata", trace_wdata, 32'h12345678);
        chk("basic_cnt", commit_cnt, 1);
        step();
        chk("basic_trace_pulse_end", trace_valid, 0);
        chk("basic_trace_hold", trace_waddr, 3);

        // Register 0 writes are discarded and are not commits.
        we = 1'b1; waddr = 0; wdata = 32'hFFFFFFFF; raddr1 = 0;
        step();
        we = 1'b0;
        #1 chk("r0_rdata1", rdata1, 0);
        chk("r0_trace_valid", trace_valid, 0);
        chk("r0_trace_waddr_hold", trace_waddr, 3);
        chk("r0_cnt", commit_cnt, 1);

        // Read enables and dual-port same-address reads.
        we = 1'b1; waddr = 7; wdata = 32'hA5A5A5A5;
        step();
        we = 1'b0; re2 = 1'b0; raddr2 = 7;
        #1 chk("re2_off", rdata2, 0);
        re2 = 1'b1;
        #1 chk("re2_on", rdata2, 32'hA5A5A5A5);
        raddr1 = 7;
        #1 chk("dual_rdata1", rdata1, 32'hA5A5A5A5);
        chk("dual_rdata2", rdata2, 32'hA5A5A5A5);
        chk("r7_cnt", commit_cnt, 2);

        // Same-cycle write/read of r9.
        we = 1'b1; waddr = 9; wdata = 32'h1;
        step();
        wdata = 32'h2; re1 = 1'b1; raddr1 = 9;
`ifdef REGFILE_WB_BYPASS_EN
        #1 chk("bypass_rdata1", rdata1, 32'h2);
`else
        #1 chk("nobypass_rdata1", rdata1, 32'h1);
`endif
        re1 = 1'b0;
        #1 chk("bypass_re_off", rdata1, 0);
        re1 = 1'b1;
        step();
        we = 1'b0;
        #1 chk("after_edge_rdata1", rdata1, 32'h2);
        chk("r9_cnt", commit_cnt, 4);

        // Counter wrap: 17 commits from reset on a 4-bit counter.
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            we = 1'b1; waddr = ADDR_W'((i % 31) + 1); wdata = 32'(i);
            step();
            if (i == 15) chk("cnt_wrap_16", commit_cnt, 0);
        end
        we = 1'b0;
        chk("cnt_wrap_17", commit_cnt, 1);
        re1 = 1'b1; raddr1 = 17;
        #1 chk("wrap_r17", rdata1, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural general-purpose register file at the receiving end of the MEM/WB pipeline register.
- Accepts the write-back triple (write enable, address, data) every cycle and commits it on the clock edge.
- Serves the two combinational operand read ports used by the decode stage.
- Keeps a registered retire trace and a commit counter for the debug/verification harness.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; entry count = 2**ADDR_W.
- CNT_W, 32, width of the commit counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write-back enable (from wb_reg).
- waddr  input  ADDR_W  write-back destination register (from wb_waddr).
- wdata  input  DATA_W  write-back data (from wb_wdata).
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data, combinational.
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data, combinational.
- trace_valid  output  1  one-cycle pulse: a commit happened on the previous edge.
- trace_waddr  output  ADDR_W  address of the last commit.
- trace_wdata  output  DATA_W  data of the last commit.
- commit_cnt  output  CNT_W  running count of commits.

Behaviour:
- Reset and reset value of every output:
  - While rst=1, asynchronously: all entries = 0, trace_valid = 0, trace_waddr = 0, trace_wdata = 0, commit_cnt = 0.
  - While rst=1, rdata1 = rdata2 = 0.
- Commit: on posedge clk with rst=0, we=1 and waddr!=0, entry[waddr] <= wdata.
  - Write latency is 1 edge.
- Register 0 is hardwired:
  - A write with waddr=0 is discarded.
  - Register 0 always reads 0.
  - A write to register 0 is not a commit: no trace pulse, no count.
- Read port n (identical for both ports), in priority order:
  1. rst=1 -> 0
  2. ren=0 -> 0
  3. raddrn=0 -> 0
  4. bypass hit (see Optional Feature) -> wdata
  5. otherwise -> entry[raddrn]
- Both ports may address the same register in the same cycle; each returns the same value.
- Trace registers, updated on every posedge clk with rst=0:
  - trace_valid <= (we && waddr!=0).
  - On a commit, trace_waddr <= waddr and trace_wdata <= wdata; otherwise both hold their values.
- Counter:
  - commit_cnt increments by 1 on each commit.
  - It wraps modulo 2**CNT_W; no saturation and no flag.
- Reset mid-operation: a write presented in the same cycle rst asserts is lost. No partial state survives.
- Undefined-address handling is not needed: every ADDR_W value maps to a valid entry.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding is enabled.
  - If we=1, waddr!=0, ren=1 and raddrn==waddr, rdatan = wdata in the same cycle.
  - This closes the WB-to-ID hazard without a stall.
- Undefined:
  - No forwarding; rdatan returns the old entry value until the commit edge.
  - The hazard is then resolved by the stall controller.

Test Plan:
- Reset values: assert rst mid-cycle (async) after writing entry[5]=0xDEADBEEF -> all outputs 0 immediately. After release, reading reg 5 returns 0 and commit_cnt = 0.
- Basic write/read: we=1, waddr=3, wdata=0x12345678 for one edge; then re1=1, raddr1=3 -> rdata1=0x12345678, trace_valid pulses 1 for one cycle, trace_waddr=3, commit_cnt=1.
- Register 0: we=1, waddr=0, wdata=0xFFFFFFFF -> reading reg 0 returns 0, trace_valid stays 0, commit_cnt unchanged.
- Read enables: entry[7]=0xA5A5A5A5 with re2=0, raddr2=7 -> rdata2=0. Set re2=1 -> rdata2=0xA5A5A5A5. With raddr1=raddr2=7 and both enables high, both ports return 0xA5A5A5A5.
- Bypass: entry[9]=0x1, then in one cycle we=1, waddr=9, wdata=0x2, re1=1, raddr1=9. With REGFILE_WB_BYPASS_EN defined, rdata1=0x2 in that cycle; without it, rdata1=0x1 in that cycle. In both builds, rdata1=0x2 after the edge.
- Counter wrap: build with CNT_W=4 and perform 17 commits to nonzero addresses -> commit_cnt=1.
